// File: rtl/vx_mem_responder.sv
// Memory-side responder for the Vortex memory bus: byte-enabled writes, fixed-latency
// reads, in-order response queue with credit-based request backpressure.
module vx_mem_responder #(
  parameter int    DATA_WIDTH      = 512,
  parameter int    BYTEEN_WIDTH    = DATA_WIDTH / 8,
  parameter int    ADDR_WIDTH      = 26,
  parameter int    TAG_WIDTH       = 8,
  parameter int    DEPTH_WORDS     = 64,
  parameter int    LATENCY         = 2,
  parameter int    RSP_QUEUE_DEPTH = 4,
  parameter string INIT_FILE       = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_rw,
  input  logic [BYTEEN_WIDTH-1:0] mem_req_byteen,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr,
  input  logic [DATA_WIDTH-1:0]   mem_req_data,
  input  logic [TAG_WIDTH-1:0]    mem_req_tag,
  output logic                    mem_req_ready,
  output logic                    mem_rsp_valid,
  output logic [DATA_WIDTH-1:0]   mem_rsp_data,
  output logic [TAG_WIDTH-1:0]    mem_rsp_tag,
  input  logic                    mem_rsp_ready,
  output logic                    tb_addr_out_of_bounds
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int PTR_W = $clog2(RSP_QUEUE_DEPTH);
  localparam int CNT_W = $clog2(RSP_QUEUE_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH_WORDS);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [TAG_WIDTH-1:0]  tag;
  } rsp_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  logic [LATENCY-1:0] vld_q, vld_d;
  rsp_t               pipe_q [LATENCY];
  rsp_t               pipe_d [LATENCY];
  rsp_t               fifo_q [RSP_QUEUE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d, outstanding_q, outstanding_d;
  logic               oob_q, oob_d;

  logic               req_fire, rd_fire, wr_fire, addr_oob, push, pop;
  logic [IDX_W-1:0]   idx;
  rsp_t               rd_entry, head;

  assign mem_req_ready = reset && (outstanding_q < CNT_W'(RSP_QUEUE_DEPTH));
  assign req_fire      = mem_req_valid && mem_req_ready;
  assign rd_fire       = req_fire && !mem_req_rw;
  assign wr_fire       = req_fire && mem_req_rw;
  assign addr_oob      = mem_req_addr >= DEPTH_A;
  assign idx           = mem_req_addr[IDX_W-1:0];

  assign rd_entry.data = addr_oob ? '0 : mem[idx];
  assign rd_entry.tag  = mem_req_tag;

  assign push = vld_q[LATENCY-1];
  assign head = fifo_q[rd_ptr_q];

  // Outputs are forced to zero whenever the queue head is not valid, which covers reset.
  assign mem_rsp_valid         = reset && (count_q != '0);
  assign mem_rsp_data          = mem_rsp_valid ? head.data : '0;
  assign mem_rsp_tag           = mem_rsp_valid ? head.tag  : '0;
  assign pop                   = mem_rsp_valid && mem_rsp_ready;
  assign tb_addr_out_of_bounds = oob_q;

  always_comb begin
    vld_d     = '0;
    vld_d[0]  = rd_fire;
    pipe_d[0] = rd_entry;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i]  = vld_q[i-1];
      pipe_d[i] = pipe_q[i-1];
    end
    wr_ptr_d      = wr_ptr_q + PTR_W'(push);
    rd_ptr_d      = rd_ptr_q + PTR_W'(pop);
    count_d       = count_q + CNT_W'(push) - CNT_W'(pop);
    outstanding_d = outstanding_q + CNT_W'(rd_fire) - CNT_W'(pop);
    oob_d         = oob_q || (req_fire && addr_oob);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      oob_q         <= 1'b0;
    end else begin
      vld_q         <= vld_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      oob_q         <= oob_d;
    end
  end

  // Payload storage carries no reset; validity lives entirely in vld_q and count_q.
  always_ff @(posedge clk) begin
    pipe_q <= pipe_d;
    if (push) fifo_q[wr_ptr_q] <= pipe_q[LATENCY-1];
  end

  always_ff @(posedge clk) begin
    if (wr_fire && !addr_oob) begin
      for (int b = 0; b < BYTEEN_WIDTH; b++) begin
        if (mem_req_byteen[b]) mem[idx][8*b +: 8] <= mem_req_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_vx_mem_responder.sv
// Directed bench for vx_mem_responder: queue-based reference model compared every
// cycle, plus literal expectations for latency, merge, ordering, bounds and reset.
module tb_vx_mem_responder;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         mem_req_valid = 1'b0, mem_req_rw = 1'b0;
  logic [63:0]  mem_req_byteen = '0;
  logic [25:0]  mem_req_addr = '0;
  logic [511:0] mem_req_data = '0;
  logic [7:0]   mem_req_tag = '0;
  logic         mem_req_ready, mem_rsp_valid, mem_rsp_ready = 1'b1;
  logic [511:0] mem_rsp_data;
  logic [7:0]   mem_rsp_tag;
  logic         tb_addr_out_of_bounds;

  vx_mem_responder dut (
    .clk(clk), .reset(reset),
    .mem_req_valid(mem_req_valid), .mem_req_rw(mem_req_rw),
    .mem_req_byteen(mem_req_byteen), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_tag(mem_req_tag),
    .mem_req_ready(mem_req_ready), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data(mem_rsp_data), .mem_rsp_tag(mem_rsp_tag),
    .mem_rsp_ready(mem_rsp_ready), .tb_addr_out_of_bounds(tb_addr_out_of_bounds)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an array of lines and a list of pending reads, each visible
  // once the edge count passes its accept edge plus the latency.
  typedef struct { logic [511:0] d; logic [7:0] tag; int t; } ent_t;
  logic [511:0] mm [64];
  ent_t         mq [$];
  int           cyc = 0;
  bit           m_flag = 1'b0;
  bit           m_rdy, m_vld;
  logic [7:0]   hs_log [$];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_flag = 1'b0;
    end else begin
      m_rdy = mq.size() < 4;
      m_vld = mq.size() > 0 && mq[0].t < cyc;
      if (m_vld && mem_rsp_ready) void'(mq.pop_front());
      if (mem_req_valid && m_rdy) begin
        if (mem_req_addr >= 64) m_flag = 1'b1;
        if (mem_req_rw) begin
          if (mem_req_addr < 64)
            for (int b = 0; b < 64; b++)
              if (mem_req_byteen[b]) mm[mem_req_addr[5:0]][8*b +: 8] = mem_req_data[8*b +: 8];
        end else begin
          mq.push_back('{(mem_req_addr < 64) ? mm[mem_req_addr[5:0]] : 512'd0, mem_req_tag, cyc + LAT});
        end
      end
      cyc++;
    end
  end

  always @(posedge clk)
    if (reset && mem_rsp_valid && mem_rsp_ready) hs_log.push_back(mem_rsp_tag);

  always @(negedge clk) begin
    bit er, ev;
    er = reset && mq.size() < 4;
    ev = reset && mq.size() > 0 && mq[0].t < cyc;
    check("req_ready", {511'd0, mem_req_ready}, {511'd0, er});
    check("rsp_valid", {511'd0, mem_rsp_valid}, {511'd0, ev});
    check("oob_flag", {511'd0, tb_addr_out_of_bounds}, {511'd0, m_flag});
    if (ev && mem_rsp_valid) begin
      check("rsp_data", mem_rsp_data, mq[0].d);
      check("rsp_tag", {504'd0, mem_rsp_tag}, {504'd0, mq[0].tag});
    end
    if (!reset) begin
      check("rst_data", mem_rsp_data, 512'd0);
      check("rst_tag", {504'd0, mem_rsp_tag}, 512'd0);
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic send(input logic rw, input logic [25:0] a, input logic [63:0] be,
                      input logic [511:0] d, input logic [7:0] tg);
    logic acc;
    mem_req_valid = 1'b1; mem_req_rw = rw; mem_req_addr = a;
    mem_req_byteen = be; mem_req_data = d; mem_req_tag = tg;
    for (int n = 0; ; n++) begin
      acc = mem_req_ready;
      tick();
      if (acc) break;
      if (n >= 50) begin check("req_accept_timeout", 512'd0, 512'd1); break; end
    end
    mem_req_valid = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [25:0] a, input logic [7:0] tg,
                            input logic [511:0] exp);
    send(1'b0, a, '0, '0, tg);
    tick();
    check({name, "_early"}, {511'd0, mem_rsp_valid}, 512'd0);
    tick();
    check({name, "_valid"}, {511'd0, mem_rsp_valid}, 512'd1);
    check({name, "_data"}, mem_rsp_data, exp);
    check({name, "_tag"}, {504'd0, mem_rsp_tag}, {504'd0, tg});
  endtask

  initial begin
    logic [511:0] pat_a5, pat_06, pat_11, pat_ff, exp_merge, hold_d;
    logic [7:0]   hold_t;
    int           base, wait_n, sz;
    pat_a5 = {16{32'hA5A5A5A5}};
    pat_06 = {16{32'h06060606}};
    pat_11 = {64{8'h11}};
    pat_ff = {64{8'hFF}};
    exp_merge = {{60{8'h11}}, {4{8'hFF}}};

    // 1: reset
    repeat (3) @(posedge clk);
    #2;
    check("rst_ready", {511'd0, mem_req_ready}, 512'd0);
    check("rst_valid", {511'd0, mem_rsp_valid}, 512'd0);
    check("rst_flag", {511'd0, tb_addr_out_of_bounds}, 512'd0);
    reset = 1'b1;
    tick();
    check("ready_after_rst", {511'd0, mem_req_ready}, 512'd1);

    // 2: full write then read with exact latency
    send(1'b1, 26'd3, '1, pat_a5, 8'h00);
    send(1'b1, 26'd6, '1, pat_06, 8'h00);
    read_check("rd3", 26'd3, 8'h05, pat_a5);
    tick();

    // 3: partial byte-enable merge
    send(1'b1, 26'd7, '1, pat_11, 8'h00);
    send(1'b1, 26'd7, 64'hF, pat_ff, 8'h00);
    read_check("merge7", 26'd7, 8'h01, exp_merge);
    tick();

    // 4: backpressure and ordering
    mem_rsp_ready = 1'b0;
    base = hs_log.size();
    for (int i = 0; i < 4; i++) send(1'b0, 26'd3, '0, '0, 8'(i));
    mem_req_valid = 1'b1; mem_req_rw = 1'b0; mem_req_addr = 26'd3; mem_req_tag = 8'd4;
    #1;
    check("ready_drop", {511'd0, mem_req_ready}, 512'd0);
    check("stall_valid", {511'd0, mem_rsp_valid}, 512'd1);
    hold_d = mem_rsp_data; hold_t = mem_rsp_tag;
    repeat (3) tick();
    check("stall_data", mem_rsp_data, hold_d);
    check("stall_tag", {504'd0, mem_rsp_tag}, {504'd0, hold_t});
    check("stall_head_tag", {504'd0, mem_rsp_tag}, 512'd0);
    check("stall_head_data", mem_rsp_data, pat_a5);
    mem_rsp_ready = 1'b1;
    send(1'b0, 26'd3, '0, '0, 8'd4);
    send(1'b0, 26'd3, '0, '0, 8'd5);
    wait_n = 0;
    while (hs_log.size() < base + 6 && wait_n < 40) begin tick(); wait_n++; end
    sz = hs_log.size();
    check("order_count", 512'(sz - base), 512'd6);
    for (int i = 0; i < 6 && base + i < sz; i++)
      check($sformatf("order_tag%0d", i), {504'd0, hs_log[base+i]}, 512'(i));
    tick();

    // 5: out-of-bounds read and write
    read_check("oob64", 26'd64, 8'h2A, 512'd0);
    check("oob_flag_set", {511'd0, tb_addr_out_of_bounds}, 512'd1);
    tick();
    send(1'b1, 26'd70, '1, pat_ff, 8'h00);
    read_check("rd6", 26'd6, 8'h06, pat_06);
    check("oob_flag_sticky", {511'd0, tb_addr_out_of_bounds}, 512'd1);
    tick();

    // 6: reset with reads in flight
    send(1'b0, 26'd3, '0, '0, 8'h10);
    send(1'b0, 26'd3, '0, '0, 8'h11);
    reset = 1'b0;
    #1;
    check("midrst_valid", {511'd0, mem_rsp_valid}, 512'd0);
    check("midrst_ready", {511'd0, mem_req_ready}, 512'd0);
    check("midrst_flag", {511'd0, tb_addr_out_of_bounds}, 512'd0);
    repeat (2) tick();
    reset = 1'b1;
    base = hs_log.size();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("post_rst_valid", {511'd0, mem_rsp_valid}, 512'd0);
      check("post_rst_ready", {511'd0, mem_req_ready}, 512'd1);
    end
    check("post_rst_no_rsp", 512'(hs_log.size() - base), 512'd0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
